// File: rtl/enigma_rotor_stage_if.sv
// rtl/enigma_rotor_stage_if.sv - handshake and control bundle for one Enigma rotor stage
//
// Purpose: groups the character streams and rotor controls of enigma_rotor_stage.
// Signals:
//   in_valid/in_ready/in_char  upstream character handshake (code in [7:0])
//   dir                        0 = forward shift, 1 = reverse shift
//   step_in                    advance the rotor on this transfer
//   load_pos/pos_in            one-cycle position load strobe and value
//   out_valid/out_ready/out_char  downstream character handshake
//   carry_out                  this character stepped the rotor off its notch
//   position                   current rotor position
// Modports: master drives the inputs of the stage, slave is the stage itself.
interface enigma_rotor_stage_if #(
  parameter int CHAR_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [CHAR_W-1:0] in_char;
  logic              dir;
  logic              step_in;
  logic              load_pos;
  logic [4:0]        pos_in;
  logic              out_valid;
  logic              out_ready;
  logic [CHAR_W-1:0] out_char;
  logic              carry_out;
  logic [4:0]        position;

  modport master (
    output in_valid, in_char, dir, step_in, load_pos, pos_in, out_ready,
    input  in_ready, out_valid, out_char, carry_out, position
  );

  modport slave (
    input  in_valid, in_char, dir, step_in, load_pos, pos_in, out_ready,
    output in_ready, out_valid, out_char, carry_out, position
  );
endinterface

// File: rtl/enigma_rotor_stage.sv
// rtl/enigma_rotor_stage.sv - clocked Enigma rotor stage with stepping and carry
//
// Purpose: substitutes one ASCII letter per transfer by a position-dependent
// Caesar shift (case preserved), forward or reverse, with a one-entry output
// register. The rotor position steps on demand and raises carry_out when it
// leaves NOTCH so stages can be cascaded.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  enigma_rotor_stage_if.slave (character handshakes, dir, step_in,
//        load_pos/pos_in, carry_out, position)
// Parameters: CHAR_W, OFFSET (wiring shift), NOTCH (carry position),
//   INIT_POS (position after reset).
// Build option: define ENIGMA_ROTOR_PASSTHRU_EN to pass non-letters through
//   unchanged; otherwise they are replaced by '?'.
module enigma_rotor_stage #(
  parameter int CHAR_W   = 16,
  parameter int OFFSET   = 1,
  parameter int NOTCH    = 25,
  parameter int INIT_POS = 0
) (
  input logic               clk,
  input logic               rst,
  enigma_rotor_stage_if.slave bus
);

  localparam logic [5:0] OFFSET_6 = 6'(OFFSET);
  localparam logic [4:0] NOTCH_5  = 5'(NOTCH);
  localparam logic [4:0] INIT_5   = 5'(INIT_POS);

  logic [4:0]        position_q, position_d;
  logic              out_valid_q, out_valid_d;
  logic [CHAR_W-1:0] out_char_q, out_char_d;
  logic              carry_q, carry_d;

  logic              in_ready;
  logic              accept;
  logic              is_upper, is_lower, is_letter;
  logic              load_ok;
  logic [4:0]        enc_pos;
  logic [5:0]        shift_sum;
  logic [4:0]        shift;
  logic [4:0]        idx;
  logic [5:0]        sel_sum;
  logic [4:0]        res;
  logic [7:0]        letter_code;
  logic [CHAR_W-1:0] enc_char;
  logic [CHAR_W-1:0] nonletter_char;
  logic              do_step;

  // Full-width compares so any set upper bit disqualifies the character.
  assign is_upper  = (bus.in_char >= CHAR_W'(65)) && (bus.in_char <= CHAR_W'(90));
  assign is_lower  = (bus.in_char >= CHAR_W'(97)) && (bus.in_char <= CHAR_W'(122));
  assign is_letter = is_upper || is_lower;

`ifdef ENIGMA_ROTOR_PASSTHRU_EN
  assign nonletter_char = bus.in_char;
`else
  assign nonletter_char = CHAR_W'(63);
`endif

  always_comb begin
    in_ready    = !out_valid_q || bus.out_ready;
    accept      = bus.in_valid && in_ready;
    load_ok     = bus.load_pos && (bus.pos_in <= 5'd25);

    // A valid load in the same cycle encodes the character with the new position.
    enc_pos     = load_ok ? bus.pos_in : position_q;
    shift_sum   = {1'b0, enc_pos} + OFFSET_6;
    shift       = (shift_sum >= 6'd26) ? 5'(shift_sum - 6'd26) : shift_sum[4:0];

    // 'A' and 'a' both have low five bits 00001, so one subtraction serves both cases.
    idx         = bus.in_char[4:0] - 5'd1;
    sel_sum     = bus.dir ? ({1'b0, idx} + 6'd26 - {1'b0, shift})
                          : ({1'b0, idx} + {1'b0, shift});
    res         = (sel_sum >= 6'd26) ? 5'(sel_sum - 6'd26) : sel_sum[4:0];
    letter_code = (is_lower ? 8'd97 : 8'd65) + {3'b000, res};
    enc_char    = is_letter ? CHAR_W'(letter_code) : nonletter_char;

    // Any load strobe takes priority over stepping, even an out-of-range one.
    do_step     = accept && is_letter && bus.step_in && !bus.load_pos;

    position_d  = position_q;
    if (load_ok) begin
      position_d = bus.pos_in;
    end else if (do_step) begin
      position_d = (position_q == 5'd25) ? 5'd0 : position_q + 5'd1;
    end

    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    carry_d     = carry_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_char_d  = enc_char;
      carry_d     = do_step && (position_q == NOTCH_5);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      position_q  <= INIT_5;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      carry_q     <= 1'b0;
    end else begin
      position_q  <= position_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      carry_q     <= carry_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_char  = out_char_q;
  assign bus.carry_out = carry_q;
  assign bus.position  = position_q;

endmodule

// File: tb/tb_enigma_rotor_stage.sv
// tb/tb_enigma_rotor_stage.sv - self-checking bench for enigma_rotor_stage
module tb_enigma_rotor_stage;
  localparam int CHAR_W   = 16;
  localparam int OFFSET   = 1;
  localparam int NOTCH    = 25;
  localparam int INIT_POS = 0;

  logic clk = 1'b0;
  logic rst;

  enigma_rotor_stage_if #(.CHAR_W(CHAR_W)) bus ();

  enigma_rotor_stage #(
    .CHAR_W(CHAR_W), .OFFSET(OFFSET), .NOTCH(NOTCH), .INIT_POS(INIT_POS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what the stage should present after each edge.
  int m_pos;
  bit m_ov;
  int m_oc;
  bit m_co;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_letter(input int code);
    return (code >= 65 && code <= 90) || (code >= 97 && code <= 122);
  endfunction

  function automatic int encode(input int code, input int pos, input bit rev);
    int base, idx, shift;
    if (!is_letter(code)) begin
`ifdef ENIGMA_ROTOR_PASSTHRU_EN
      return code;
`else
      return 63;
`endif
    end
    base  = (code >= 97) ? 97 : 65;
    idx   = code - base;
    shift = (pos + OFFSET) % 26;
    return rev ? base + (idx - shift + 26) % 26 : base + (idx + shift) % 26;
  endfunction

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic cycle(input bit v, input int ch, input bit d, input bit s,
                       input bit ld, input int p, input bit ordy);
    bit rdy, acc, lv, stp;
    int epos;
    bus.in_valid  = v;
    bus.in_char   = CHAR_W'(ch);
    bus.dir       = d;
    bus.step_in   = s;
    bus.load_pos  = ld;
    bus.pos_in    = 5'(p);
    bus.out_ready = ordy;
    #1;
    rdy  = !m_ov || ordy;
    check("in_ready", bus.in_ready, rdy);
    acc  = v && rdy;
    lv   = ld && (p <= 25);
    epos = lv ? p : m_pos;
    stp  = acc && is_letter(ch) && s && !ld;
    @(posedge clk);
    #1;
    if (acc) begin
      m_oc = encode(ch, epos, d);
      m_co = stp && (m_pos == NOTCH);
      m_ov = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    m_pos = lv ? p : (stp ? (m_pos + 1) % 26 : m_pos);
    check("out_valid", bus.out_valid, m_ov);
    check("position", bus.position, m_pos);
    if (m_ov) begin
      check("out_char", bus.out_char, m_oc);
      check("carry_out", bus.carry_out, m_co);
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    m_pos = INIT_POS;
    m_ov  = 1'b0;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_position", bus.position, INIT_POS);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int r, ch;
    bus.in_valid  = 1'b0;
    bus.in_char   = '0;
    bus.dir       = 1'b0;
    bus.step_in   = 1'b0;
    bus.load_pos  = 1'b0;
    bus.pos_in    = '0;
    bus.out_ready = 1'b1;
    rst   = 1'b1;
    m_pos = INIT_POS;
    m_ov  = 1'b0;
    m_oc  = 0;
    m_co  = 1'b0;
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_char", bus.out_char, 0);
    check("reset_carry", bus.carry_out, 0);
    check("reset_position", bus.position, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_in_ready", bus.in_ready, 1);

    cycle(1, 65, 0, 0, 0, 0, 1);
    check("A_to_B", bus.out_char, 66);
    check("A_pos", bus.position, 0);
    check("A_carry", bus.carry_out, 0);

    cycle(1, 97, 0, 1, 0, 0, 1);
    check("a1", bus.out_char, 98);
    cycle(1, 97, 0, 1, 0, 0, 1);
    check("a2", bus.out_char, 99);
    cycle(1, 97, 0, 1, 0, 0, 1);
    check("a3", bus.out_char, 100);
    check("a_pos", bus.position, 3);

    cycle(0, 0, 0, 0, 1, 25, 1);
    check("load25", bus.position, 25);
    cycle(1, 90, 0, 1, 0, 0, 1);
    check("notch_char", bus.out_char, 90);
    check("notch_carry", bus.carry_out, 1);
    check("notch_wrap", bus.position, 0);
    cycle(1, 65, 0, 1, 1, 2, 1);
    check("loadacc_char", bus.out_char, 68);
    check("loadacc_pos", bus.position, 2);
    check("loadacc_carry", bus.carry_out, 0);

    cycle(0, 0, 0, 0, 1, 0, 1);
    cycle(1, 66, 1, 0, 0, 0, 1);
    check("rev_B", bus.out_char, 65);
    cycle(1, 65, 1, 0, 0, 0, 1);
    check("rev_A", bus.out_char, 90);
    cycle(1, 97, 1, 0, 0, 0, 1);
    check("rev_a", bus.out_char, 122);

    cycle(1, 53, 0, 1, 0, 0, 1);
`ifdef ENIGMA_ROTOR_PASSTHRU_EN
    check("digit", bus.out_char, 53);
`else
    check("digit", bus.out_char, 63);
`endif
    check("digit_pos", bus.position, 0);
    cycle(0, 0, 0, 0, 1, 30, 1);
    check("bad_load", bus.position, 0);

    cycle(1, 67, 0, 1, 0, 0, 0);
    check("hold_C", bus.out_char, 68);
    cycle(1, 68, 0, 0, 0, 0, 0);
    check("hold_char", bus.out_char, 68);
    check("hold_ready", bus.in_ready, 0);
    check("hold_pos", bus.position, 1);
    do_reset();
    cycle(1, 68, 0, 0, 0, 0, 1);
    check("after_rst_D", bus.out_char, 69);

    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      ch = $urandom_range(65, 90);
      else if (r < 8) ch = $urandom_range(97, 122);
      else if (r < 9) ch = $urandom_range(32, 126);
      else            ch = $urandom_range(0, 65535);
      if ($urandom_range(0, 399) == 0) do_reset();
      cycle($urandom_range(0, 3) != 0, ch, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 31), $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
